// File: rtl/cgmii_pkg.sv
// Shared constants, state encoding and block helpers for the CGMII frame generator.
package cgmii_pkg;

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned CTRL_W = 8;

  // Whole-block encodings, byte0 in [63:56]
  localparam logic [BLK_W-1:0] Q_ORD_BLOCK = 64'h9C68_7973_0000_0000;
  localparam logic [BLK_W-1:0] IDLE_BLOCK  = 64'h0707_0707_0707_0707;
  localparam logic [BLK_W-1:0] ERROR_BLOCK = 64'hFEFE_FEFE_FEFE_FEFE;

  localparam logic [7:0] START_BYTE = 8'hFB;
  localparam logic [7:0] TERM_BYTE  = 8'hFD;
  localparam logic [7:0] IDLE_BYTE  = 8'h07;

  // Control masks, bit7 belongs to byte0
  localparam logic [CTRL_W-1:0] CTRL_ALL  = 8'hFF;
  localparam logic [CTRL_W-1:0] CTRL_NONE = 8'h00;
  localparam logic [CTRL_W-1:0] CTRL_LEAD = 8'h80;

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_START = 5'b00010,
    ST_DATA  = 5'b00100,
    ST_TERM  = 5'b01000,
    ST_IDLE  = 5'b10000
  } state_e;

  // Terminate block: k payload bytes kept from prbs, then FD, then idles
  function automatic logic [BLK_W-1:0] term_block(input logic [BLK_W-1:0] prbs,
                                                   input logic [2:0]       k);
    logic [BLK_W-1:0] d;
    d = IDLE_BLOCK;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(k)) begin
        d[63-8*i -: 8] = prbs[63-8*i -: 8];
      end else if (i == int'(k)) begin
        d[63-8*i -: 8] = TERM_BYTE;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/prbs64_gen.sv
// 31-bit LFSR (x^31 + x^28 + 1) producing 64 fresh bits per enable.
// o_data holds the next unused word; the oldest generated bit sits in bit 63.
module prbs64_gen #(
  parameter logic [30:0] SEED = 31'h7FFFFFFF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  output logic [63:0] o_data
);

  localparam int unsigned LFSR_W = 31;
  localparam int unsigned WORD_W = 64;

  // Run the LFSR 64 steps; returns {final state, generated word}
  function automatic logic [LFSR_W+WORD_W-1:0] step64(input logic [LFSR_W-1:0] s_in);
    logic [LFSR_W-1:0] s;
    logic [WORD_W-1:0] w;
    logic              nb;
    s = s_in;
    w = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      nb          = s[30] ^ s[27];
      w[63-i]     = nb;
      s           = {s[29:0], nb};
    end
    return {s, w};
  endfunction

  localparam logic [LFSR_W+WORD_W-1:0] RESET_VAL = step64(SEED);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [WORD_W-1:0] data_q, data_d;

  // Next state and word, taken only when enabled
  always_comb begin
    lfsr_d = lfsr_q;
    data_d = data_q;
    if (i_enable) begin
      {lfsr_d, data_d} = step64(lfsr_q);
    end
  end

  // LFSR state and pre-computed word
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      {lfsr_q, data_q} <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
      data_q <= data_d;
    end
  end

  assign o_data = data_q;

endmodule

// File: rtl/cgmii_frame_gen.sv
// CGMII test-traffic source: INIT ordered sets, then START / DATA / TERM / IDLE
// frames with PRBS payload, valid/ready handshake and frame counter.
// Optional error injection is compiled in with CGMII_FRAME_GEN_ERR_INJ_EN.
module cgmii_frame_gen
  import cgmii_pkg::*;
#(
  parameter int unsigned NB_DATA   = 64,
  parameter int unsigned NB_CTRL   = 8,
  parameter int unsigned NB_LEN    = 16,
  parameter int unsigned NB_IDLE   = 8,
  parameter int unsigned N_INIT_OS = 4,
  parameter logic [30:0] PRBS_SEED = 31'h7FFFFFFF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_LEN-1:0]  i_cfg_ndata,
  input  logic [NB_IDLE-1:0] i_cfg_nidle,
  input  logic [2:0]         i_cfg_nterm,
  input  logic               i_ready,
  input  logic               i_err_inject,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_CTRL-1:0] o_tx_ctrl,
  output logic               o_valid,
  output logic [NB_LEN-1:0]  o_frame_count
);

  localparam int unsigned NB_OS = 4;

  state_e             state_q, state_d;
  logic [NB_OS-1:0]   os_cnt_q, os_cnt_d;
  logic [NB_LEN-1:0]  blk_cnt_q, blk_cnt_d;
  logic [NB_LEN-1:0]  ndata_q, ndata_d;
  logic [NB_IDLE-1:0] nidle_q, nidle_d;
  logic [2:0]         nterm_q, nterm_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_CTRL-1:0] ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  logic [NB_LEN-1:0]  fcnt_q, fcnt_d;
  logic               prbs_en;
  logic [63:0]        prbs_data;

`ifdef CGMII_FRAME_GEN_ERR_INJ_EN
  logic               err_q, err_d;
`else
  logic               err_inject_unused;
  assign err_inject_unused = i_err_inject;
`endif

  prbs64_gen #(
    .SEED (PRBS_SEED)
  ) u_prbs (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (prbs_en),
    .o_data   (prbs_data)
  );

  // Next-state and next-word logic; everything holds unless the current beat is taken
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    blk_cnt_d = blk_cnt_q;
    ndata_d   = ndata_q;
    nidle_d   = nidle_q;
    nterm_d   = nterm_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    fcnt_d    = fcnt_q;
    prbs_en   = 1'b0;
`ifdef CGMII_FRAME_GEN_ERR_INJ_EN
    err_d     = err_q | i_err_inject;
`endif
    if (!valid_q || i_ready) begin
      if (!i_enable) begin
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        case (state_q)
          ST_INIT: begin
            data_d = NB_DATA'(Q_ORD_BLOCK);
            ctrl_d = NB_CTRL'(CTRL_LEAD);
            if (os_cnt_q == NB_OS'(N_INIT_OS - 1)) begin
              os_cnt_d = '0;
              state_d  = ST_START;
            end else begin
              os_cnt_d = os_cnt_q + NB_OS'(1);
            end
          end
          ST_START: begin
            data_d    = NB_DATA'({START_BYTE, prbs_data[55:0]});
            ctrl_d    = NB_CTRL'(CTRL_LEAD);
            prbs_en   = 1'b1;
            ndata_d   = i_cfg_ndata;
            nidle_d   = i_cfg_nidle;
            nterm_d   = i_cfg_nterm;
            blk_cnt_d = '0;
            state_d   = (i_cfg_ndata != '0) ? ST_DATA : ST_TERM;
          end
          ST_DATA: begin
            data_d  = NB_DATA'(prbs_data);
            ctrl_d  = NB_CTRL'(CTRL_NONE);
            prbs_en = 1'b1;
`ifdef CGMII_FRAME_GEN_ERR_INJ_EN
            if (err_q) begin
              data_d = NB_DATA'(ERROR_BLOCK);
              ctrl_d = NB_CTRL'(CTRL_ALL);
              err_d  = i_err_inject;
            end
`endif
            if (blk_cnt_q == ndata_q - NB_LEN'(1)) begin
              blk_cnt_d = '0;
              state_d   = ST_TERM;
            end else begin
              blk_cnt_d = blk_cnt_q + NB_LEN'(1);
            end
          end
          ST_TERM: begin
            data_d    = NB_DATA'(term_block(prbs_data, nterm_q));
            ctrl_d    = NB_CTRL'(CTRL_ALL >> nterm_q);
            prbs_en   = 1'b1;
            fcnt_d    = fcnt_q + NB_LEN'(1);
            blk_cnt_d = '0;
            state_d   = (nidle_q != '0) ? ST_IDLE : ST_START;
          end
          ST_IDLE: begin
            data_d = NB_DATA'(IDLE_BLOCK);
            ctrl_d = NB_CTRL'(CTRL_ALL);
            if (blk_cnt_q == NB_LEN'(nidle_q) - NB_LEN'(1)) begin
              blk_cnt_d = '0;
              state_d   = ST_START;
            end else begin
              blk_cnt_d = blk_cnt_q + NB_LEN'(1);
            end
          end
          default: begin
            state_d = ST_INIT;
          end
        endcase
      end
    end
  end

  // State, shadow config and registered outputs
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_INIT;
      os_cnt_q  <= '0;
      blk_cnt_q <= '0;
      ndata_q   <= '0;
      nidle_q   <= '0;
      nterm_q   <= '0;
      data_q    <= NB_DATA'(IDLE_BLOCK);
      ctrl_q    <= NB_CTRL'(CTRL_ALL);
      valid_q   <= 1'b0;
      fcnt_q    <= '0;
`ifdef CGMII_FRAME_GEN_ERR_INJ_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      ndata_q   <= ndata_d;
      nidle_q   <= nidle_d;
      nterm_q   <= nterm_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      fcnt_q    <= fcnt_d;
`ifdef CGMII_FRAME_GEN_ERR_INJ_EN
      err_q     <= err_d;
`endif
    end
  end

  assign o_tx_data     = data_q;
  assign o_tx_ctrl     = ctrl_q;
  assign o_valid       = valid_q;
  assign o_frame_count = fcnt_q;

endmodule

// File: tb/tb_cgmii_frame_gen.sv
// Scoreboard bench for cgmii_frame_gen: a frame-level reference model pushes
// expected words; a monitor pops one per accepted beat and compares.
module tb_cgmii_frame_gen;

  localparam logic [30:0] SEED     = 31'h7FFFFFFF;
  localparam int          N_OS     = 4;
  localparam int          WAIT_MAX = 3000;

  localparam int K_QORD  = 0;
  localparam int K_START = 1;
  localparam int K_DATA  = 2;
  localparam int K_TERM  = 3;
  localparam int K_IDLE  = 4;
  localparam int K_ERR   = 5;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic [15:0] cnt;
    int          kind;
    int          fid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] cfg_ndata;
  logic [7:0]  cfg_nidle;
  logic [2:0]  cfg_nterm;
  logic        ready;
  logic        inj;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_ctrl;
  logic        o_valid;
  logic [15:0] o_frame_count;

  int          errors = 0;
  int          checks = 0;

  exp_t        exp_q[$];
  bit          hist[$];
  logic [15:0] model_cnt;
  int          model_fid = 0;
  int          sched_idx = 0;
  int          sched_nd[9] = '{2, 0, 0, 2, 5, 1,  2, 3, 1};
  int          sched_nt[9] = '{3, 0, 0, 3, 6, 7,  3, 1, 4};
  int          sched_ni[9] = '{2, 0, 0, 1, 1, 0,  2, 2, 0};
  int          post_fid;

  cgmii_frame_gen #(
    .NB_DATA   (64),
    .NB_CTRL   (8),
    .NB_LEN    (16),
    .NB_IDLE   (8),
    .N_INIT_OS (N_OS),
    .PRBS_SEED (SEED)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_enable      (en),
    .i_cfg_ndata   (cfg_ndata),
    .i_cfg_nidle   (cfg_nidle),
    .i_cfg_nterm   (cfg_nterm),
    .i_ready       (ready),
    .i_err_inject  (inj),
    .o_tx_data     (o_tx_data),
    .o_tx_ctrl     (o_tx_ctrl),
    .o_valid       (o_valid),
    .o_frame_count (o_frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // PRBS bit stream: b[n] = b[n-31] ^ b[n-28], history primed with the seed (bit 30 oldest)
  task automatic next_word(output logic [63:0] w);
    bit nb;
    for (int i = 0; i < 64; i++) begin
      nb = hist[0] ^ hist[3];
      hist.push_back(nb);
      void'(hist.pop_front());
      w[63-i] = nb;
    end
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] c, input int kind);
    exp_t e;
    e.d = d; e.c = c; e.cnt = model_cnt; e.kind = kind; e.fid = model_fid;
    exp_q.push_back(e);
  endtask

  // Expected words for one frame: START, nd DATA, TERM(nt), ni IDLE
  task automatic push_frame(input int nd, input int nt, input int ni);
    logic [63:0] w;
    logic [63:0] t;
    logic [7:0]  c;
    next_word(w);
    push_word({8'hFB, w[55:0]}, 8'h80, K_START);
    for (int i = 0; i < nd; i++) begin
      next_word(w);
      push_word(w, 8'h00, K_DATA);
    end
    next_word(w);
    for (int i = 0; i < 8; i++) begin
      if (i < nt)       t[63-8*i -: 8] = w[63-8*i -: 8];
      else if (i == nt) t[63-8*i -: 8] = 8'hFD;
      else              t[63-8*i -: 8] = 8'h07;
      c[7-i] = (i >= nt);
    end
    model_cnt = model_cnt + 16'd1;
    push_word(t, c, K_TERM);
    for (int i = 0; i < ni; i++) push_word(64'h0707070707070707, 8'hFF, K_IDLE);
    model_fid++;
  endtask

  // Drive the config the DUT will latch at its next START and queue that frame
  task automatic push_next_frame();
    int nd, nt, ni;
    if (sched_idx < 9) begin
      nd = sched_nd[sched_idx]; nt = sched_nt[sched_idx]; ni = sched_ni[sched_idx];
    end else begin
      nd = int'($urandom_range(0, 4)); nt = int'($urandom_range(0, 7)); ni = int'($urandom_range(0, 3));
    end
    sched_idx++;
    cfg_ndata = 16'(nd);
    cfg_nterm = 3'(nt);
    cfg_nidle = 8'(ni);
    push_frame(nd, nt, ni);
  endtask

  task automatic model_init(input int first_sched);
    exp_q.delete();
    hist.delete();
    for (int i = 30; i >= 0; i--) hist.push_back(SEED[i]);
    model_cnt = 16'd0;
    sched_idx = first_sched;
    for (int i = 0; i < N_OS; i++) push_word(64'h9C68797300000000, 8'h80, K_QORD);
    push_next_frame();
  endtask

  // Wait (at posedge+1) until the DUT presents the head word of the given kind/frame (fid<0: any)
  task automatic wait_head(input string name, input int kind, input int fid);
    bit hit = 1'b0;
    for (int n = 0; n < WAIT_MAX && !hit; n++) begin
      @(posedge clk); #1;
      if (o_valid && exp_q.size() > 0)
        if (exp_q[0].kind == kind && (fid < 0 || exp_q[0].fid == fid)) hit = 1'b1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for kind %0d frame %0d", name, kind, fid);
    end
  endtask

  task automatic random_phase(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      ready = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 7) != 0);
    end
    @(posedge clk); #1;
    ready = 1'b1; en = 1'b1;
  endtask

  // Monitor: compare every accepted beat against the scoreboard; check stall holds
  initial begin : monitor
    exp_t        e;
    bit          stall_prev = 1'b0;
    logic [63:0] prev_d;
    logic [7:0]  prev_c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", 64'(o_valid), 64'd1);
          chk("stall_data", o_tx_data, prev_d);
          chk("stall_ctrl", 64'(o_tx_ctrl), 64'(prev_c));
        end
        if (o_valid && ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %h/%h with empty scoreboard", o_tx_data, o_tx_ctrl);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("data_k%0d_f%0d", e.kind, e.fid), o_tx_data, e.d);
            chk($sformatf("ctrl_k%0d_f%0d", e.kind, e.fid), 64'(o_tx_ctrl), 64'(e.c));
            chk($sformatf("count_k%0d_f%0d", e.kind, e.fid), 64'(o_frame_count), 64'(e.cnt));
            if (e.kind == K_START) push_next_frame();
          end
        end
        stall_prev = o_valid && !ready;
        prev_d     = o_tx_data;
        prev_c     = o_tx_ctrl;
      end
    end
  end

  initial begin : stimulus
    exp_t tmp;
    bit   done;
    rst_n = 1'b0; en = 1'b0; ready = 1'b1; inj = 1'b0;
    cfg_ndata = 16'd0; cfg_nidle = 8'd0; cfg_nterm = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_data", o_tx_data, 64'h0707070707070707);
    chk("reset_ctrl", 64'(o_tx_ctrl), 64'hFF);
    chk("reset_count", 64'(o_frame_count), 64'd0);

    model_init(0);
    rst_n = 1'b1;
    en    = 1'b1;

    // 5-cycle stall on a DATA word of frame 3; frame 4 picks up ndata=5
    wait_head("wait_f3_data", K_DATA, 3);
    ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ready = 1'b1;

    random_phase(600);

    // Reset while a TERM is on the bus
    wait_head("wait_term", K_TERM, -1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(o_valid), 64'd0);
    chk("midreset_count", 64'(o_frame_count), 64'd0);
    chk("midreset_data", o_tx_data, 64'h0707070707070707);
    chk("midreset_ctrl", 64'(o_tx_ctrl), 64'hFF);
    repeat (2) @(posedge clk);
    #1;
    post_fid = model_fid;
    model_init(6);
    rst_n = 1'b1;

    // Error-inject pulse while IDLE of the first post-reset frame is presented
    wait_head("wait_idle", K_IDLE, post_fid);
    inj = 1'b1;
`ifdef CGMII_FRAME_GEN_ERR_INJ_EN
    done = 1'b0;
    foreach (exp_q[i]) begin
      if (!done && exp_q[i].kind == K_DATA) begin
        tmp = exp_q[i];
        tmp.d = 64'hFEFEFEFEFEFEFEFE; tmp.c = 8'hFF; tmp.kind = K_ERR;
        exp_q[i] = tmp;
        done = 1'b1;
      end
    end
`else
    done = 1'b1;
    tmp  = exp_q[0];
`endif
    @(posedge clk); #1;
    inj = 1'b0;

    wait_head("wait_post_start", K_START, post_fid + 3);
    random_phase(400);

    // Drain: pause and let the presented word go
    en = 1'b0;
    ready = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(posedge clk); #1;
      if (!o_valid) done = 1'b1;
    end
    chk("drain_valid_low", 64'(o_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
